// File: rtl/vseq_pkg.sv
// ---------------------------------------------------------------------------
// vseq_pkg: shared definitions for the vector display-list sequencer.
//   - vseq_state_e : sequencer FSM state encoding (3 bits)
//   - *_LSB        : bit positions of the four 8-bit fields in a list entry
//                    {stax[31:24], stay[23:16], endx[15:8], endy[7:0]}
//   - ARM_TIMEOUT  : cycles to wait for the engine to acknowledge go
//   - entry_field  : extracts one 8-bit coordinate from a list entry
// ---------------------------------------------------------------------------
package vseq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        LAUNCH = 3'd3,
        ARM    = 3'd4,
        DRAW   = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } vseq_state_e;

    localparam int FIELD_W  = 8;
    localparam int STAX_LSB = 24;
    localparam int STAY_LSB = 16;
    localparam int ENDX_LSB = 8;
    localparam int ENDY_LSB = 0;

    localparam int ARM_TIMEOUT = 2;
    localparam int ARM_W       = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;

    function automatic logic [FIELD_W-1:0] entry_field(input logic [31:0] entry,
                                                       input int          lsb);
        return entry[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/vector_seq.sv
// ---------------------------------------------------------------------------
// vector_seq: display-list sequencer feeding the line-drawing engine.
// Walks num_segs entries of the list RAM starting at BASE_ADDR; for each one
// it reads the entry, registers the endpoints, pulses ld_go and waits for the
// engine to finish, then signals frame_done at the end of the list.
//
// Ports:
//   pclk, rst            clock, asynchronous active-high reset
//   start, num_segs      frame request (sampled in IDLE) and segment count
//   busy, frame_done     frame in progress / one-cycle end-of-frame pulse
//   mem_addr, mem_rd     list RAM read port; mem_data valid 1 cycle later
//   mem_data             list entry {stax, stay, endx, endy}
//   ld_go, ld_busy       engine go pulse and engine busy status
//   ld_stax..ld_endy     registered endpoints to the engine
//   blank                beam blank, low only while a line is being drawn
//   repeat_i             (VSEQ_REPEAT_EN only) redraw the list continuously
//
// Build option: define VSEQ_REPEAT_EN to add repeat_i and frame looping.
// ---------------------------------------------------------------------------
module vector_seq
    import vseq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_segs,
    output logic              busy,
    output logic              frame_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_data,
    output logic              ld_go,
    input  logic              ld_busy,
    output logic [7:0]        ld_stax,
    output logic [7:0]        ld_stay,
    output logic [7:0]        ld_endx,
    output logic [7:0]        ld_endy,
    output logic              blank
`ifdef VSEQ_REPEAT_EN
    ,
    input  logic              repeat_i
`endif
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_SEGS = {1'b1, {ADDR_W{1'b0}}};

    vseq_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   cnt_inc;
    logic [ARM_W-1:0]  arm_q, arm_d;
    logic              done_q, done_d;
    logic              blank_q, blank_d;
    logic [7:0]        stax_q, stax_d;
    logic [7:0]        stay_q, stay_d;
    logic [7:0]        endx_q, endx_d;
    logic [7:0]        endy_q, endy_d;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            cnt_q   <= '0;
            count_q <= '0;
            arm_q   <= '0;
            done_q  <= 1'b0;
            blank_q <= 1'b1;
            stax_q  <= '0;
            stay_q  <= '0;
            endx_q  <= '0;
            endy_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            arm_q   <= arm_d;
            done_q  <= done_d;
            blank_q <= blank_d;
            stax_q  <= stax_d;
            stay_q  <= stay_d;
            endx_q  <= endx_d;
            endy_q  <= endy_d;
        end
    end

    assign cnt_inc = cnt_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        arm_d   = arm_q;
        done_d  = 1'b0;
        stax_d  = stax_q;
        stay_d  = stay_q;
        endx_d  = endx_q;
        endy_d  = endy_q;
        // Registered so blank only reacts to a line the sequencer is tracking,
        // not to an engine still finishing after a reset.
        blank_d = ~((state_q == DRAW) && ld_busy);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_segs == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // Counts beyond the list size are clipped to a full list.
                        count_d = (num_segs > MAX_SEGS) ? MAX_SEGS : num_segs;
                        cnt_d   = '0;
                        addr_d  = BASE;
                        state_d = FETCH;
                    end
                end
            end
            FETCH:  state_d = LOAD;
            LOAD: begin
                // mem_data is valid in this cycle, one after the FETCH read.
                stax_d  = entry_field(mem_data, STAX_LSB);
                stay_d  = entry_field(mem_data, STAY_LSB);
                endx_d  = entry_field(mem_data, ENDX_LSB);
                endy_d  = entry_field(mem_data, ENDY_LSB);
                state_d = LAUNCH;
            end
            LAUNCH: begin
                arm_d   = '0;
                state_d = ARM;
            end
            ARM: begin
                // An engine that missed go would otherwise stall the frame.
                if (ld_busy) begin
                    state_d = DRAW;
                end else if (arm_q == ARM_W'(ARM_TIMEOUT - 1)) begin
                    state_d = NEXT;
                end else begin
                    arm_d = arm_q + ARM_W'(1);
                end
            end
            DRAW: begin
                if (!ld_busy) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                cnt_d  = cnt_inc;
                addr_d = addr_q + ADDR_W'(1);
                if (cnt_inc == count_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                end
            end
            DONE: begin
`ifdef VSEQ_REPEAT_EN
                if (repeat_i) begin
                    addr_d  = BASE;
                    cnt_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign mem_addr   = addr_q;
    assign mem_rd     = (state_q == FETCH);
    assign ld_go      = (state_q == LAUNCH);
    assign ld_stax    = stax_q;
    assign ld_stay    = stay_q;
    assign ld_endx    = endx_q;
    assign ld_endy    = endy_q;
    assign blank      = blank_q;

endmodule

// File: tb/tb_vector_seq.sv
// ---------------------------------------------------------------------------
// tb_vector_seq: self-checking bench for vector_seq (ADDR_W=4, BASE_ADDR=4).
// Provides a synchronous list RAM and a behavioural line engine whose busy
// time is max(|dx|,|dy|)+1 cycles, and checks fetched addresses, launched
// endpoints, frame timing, handshake signals and blanking against a model.
// ---------------------------------------------------------------------------
module tb_vector_seq;

    localparam int AW     = 4;
    localparam int BASE   = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int BUDGET = 5000;

    logic          pclk     = 1'b0;
    logic          rst      = 1'b1;
    logic          start    = 1'b0;
    logic [AW:0]   num_segs = '0;
    logic          busy, frame_done, mem_rd, ld_go, blank;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data = '0;
    logic          ld_busy  = 1'b0;
    logic [7:0]    ld_stax, ld_stay, ld_endx, ld_endy;
`ifdef VSEQ_REPEAT_EN
    logic          repeat_i = 1'b0;
`endif

    int            n_tests  = 0;
    int            n_fail   = 0;
    logic [31:0]   mem [DEPTH];
    int            eng_left = 0;
    bit            eng_deaf = 1'b0;
    logic [31:0]   eng_ep   = '0;
    int            stab_err = 0;
    logic [AW-1:0] obs_addr [$];
    logic [31:0]   obs_ep   [$];
    int            fd_cnt   = 0;
    bit            owns     = 1'b0;
    logic          b1       = 1'b0;
    logic          b2       = 1'b0;

    always #5 pclk = ~pclk;

    vector_seq #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .start     (start),
        .num_segs  (num_segs),
        .busy      (busy),
        .frame_done(frame_done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .ld_go     (ld_go),
        .ld_busy   (ld_busy),
        .ld_stax   (ld_stax),
        .ld_stay   (ld_stay),
        .ld_endx   (ld_endx),
        .ld_endy   (ld_endy),
        .blank     (blank)
`ifdef VSEQ_REPEAT_EN
        ,
        .repeat_i  (repeat_i)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int seglen(input logic [31:0] e);
        int dx, dy;
        dx = iabs(int'(e[15:8]) - int'(e[31:24]));
        dy = iabs(int'(e[7:0])  - int'(e[23:16]));
        return ((dx > dy) ? dx : dy) + 1;
    endfunction

    function automatic logic [7:0] near(input logic [7:0] v);
        return 8'(int'(v) + int'($urandom_range(0, 16)) - 8);
    endfunction

    function automatic logic [31:0] rand_entry();
        logic [7:0] sx, sy;
        sx = 8'($urandom_range(16, 239));
        sy = 8'($urandom_range(16, 239));
        return {sx, sy, near(sx), near(sy)};
    endfunction

    // synchronous list RAM: data valid the cycle after the read strobe
    always @(posedge pclk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // behavioural line engine; keeps running through a sequencer reset
    always @(posedge pclk) begin
        if (eng_left > 0) begin
            if ({ld_stax, ld_stay, ld_endx, ld_endy} != eng_ep) stab_err++;
            eng_left--;
        end else if (ld_go && !eng_deaf) begin
            eng_ep   = {ld_stax, ld_stay, ld_endx, ld_endy};
            eng_left = seglen(eng_ep);
        end
        ld_busy <= (eng_left > 0);
    end

    // per-cycle monitor: blank expected low only in the cycle after a cycle
    // where the sequencer was drawing a line it launched and the engine was busy
    always @(negedge pclk) begin
        if (rst) owns = 1'b0;
        chk("blank", 64'(blank), 64'(!(owns && b1 && b2)));
        if (mem_rd) obs_addr.push_back(mem_addr);
        if (ld_go) begin
            obs_ep.push_back({ld_stax, ld_stay, ld_endx, ld_endy});
            owns = 1'b1;
        end
        if (frame_done) fd_cnt++;
        b2 = b1;
        b1 = ld_busy;
    end

    task automatic chk_reset_outputs();
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_done",  64'(frame_done), 64'(0));
        chk("rst_rd",    64'(mem_rd), 64'(0));
        chk("rst_addr",  64'(mem_addr), 64'(BASE));
        chk("rst_go",    64'(ld_go), 64'(0));
        chk("rst_ep",    64'({ld_stax, ld_stay, ld_endx, ld_endy}), 64'(0));
        chk("rst_blank", 64'(blank), 64'(1));
    endtask

    task automatic clear_obs();
        #1;
        obs_addr.delete();
        obs_ep.delete();
        fd_cnt   = 0;
        stab_err = 0;
    endtask

    task automatic run_frame(input int n, input bit deaf);
        int            nc, exp_cyc, cyc, lows;
        logic [AW-1:0] a;
        nc       = (n > DEPTH) ? DEPTH : n;
        eng_deaf = deaf;
        exp_cyc  = 1;
        for (int i = 0; i < nc; i++) begin
            a = AW'((BASE + i) % DEPTH);
            exp_cyc += deaf ? 6 : 5 + seglen(mem[a]);
        end
        clear_obs();
        @(negedge pclk);
        start    = 1'b1;
        num_segs = (AW+1)'(n);
        @(negedge pclk);
        start    = 1'b0;
        num_segs = (AW+1)'($urandom_range(0, 31));
        if (nc == 0) begin
            chk("zero_done", 64'(frame_done), 64'(1));
            chk("zero_busy", 64'(busy), 64'(0));
            for (int i = 0; i < 3; i++) begin
                @(negedge pclk);
                chk("zero_idle", 64'({busy, frame_done}), 64'(0));
            end
            #1;
            chk("zero_fd_cnt", 64'(fd_cnt), 64'(1));
            chk("zero_rd_cnt", 64'(obs_addr.size()), 64'(0));
            chk("zero_go_cnt", 64'(obs_ep.size()), 64'(0));
            return;
        end
        chk("busy_rise", 64'(busy), 64'(1));
        cyc  = 1;
        lows = 0;
        while (!frame_done && cyc < BUDGET) begin
            @(negedge pclk);
            cyc++;
            start = (cyc == 3);
            if (!busy) lows++;
        end
        start = 1'b0;
        chk("frame_timeout", 64'(frame_done), 64'(1));
        chk("frame_cycles", 64'(cyc), 64'(exp_cyc));
        chk("busy_hold", 64'(lows), 64'(0));
        @(negedge pclk);
        chk("busy_fall", 64'(busy), 64'(0));
        chk("done_width", 64'(frame_done), 64'(0));
        #1;
        chk("fd_cnt", 64'(fd_cnt), 64'(1));
        chk("rd_cnt", 64'(obs_addr.size()), 64'(nc));
        chk("go_cnt", 64'(obs_ep.size()), 64'(nc));
        chk("ep_stable", 64'(stab_err), 64'(0));
        for (int i = 0; i < nc && i < obs_addr.size() && i < obs_ep.size(); i++) begin
            a = AW'((BASE + i) % DEPTH);
            chk("addr", 64'(obs_addr[i]), 64'(a));
            chk("endpoints", 64'(obs_ep[i]), 64'(mem[a]));
        end
    endtask

    initial begin
        int k, lfd, lows;
        for (int i = 0; i < DEPTH; i++) mem[AW'(i)] = rand_entry();
        repeat (2) @(negedge pclk);
        #1;
        chk_reset_outputs();
        @(negedge pclk);
        #2 rst = 1'b0;

        run_frame(0, 1'b0);
        mem[AW'(BASE)] = {8'd10, 8'd10, 8'd13, 8'd12};
        run_frame(1, 1'b0);
        mem[AW'(BASE + 1)] = {8'd50, 8'd60, 8'd50, 8'd60};
        run_frame(3, 1'b0);
        run_frame(3, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) mem[AW'(i)] = rand_entry();
            run_frame(int'($urandom_range(1, 6)), $urandom_range(0, 3) == 0);
        end
        run_frame(14, 1'b0);
        run_frame(20, 1'b0);
        run_frame(16, 1'b1);

        // reset while ld_go is high
        eng_deaf = 1'b0;
        clear_obs();
        @(negedge pclk);
        start = 1'b1; num_segs = (AW+1)'(2);
        @(negedge pclk);
        start = 1'b0;
        k = 0;
        while (!ld_go && k < 50) begin @(negedge pclk); k++; end
        chk("launch_seen", 64'(ld_go), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("go_drop", 64'(ld_go), 64'(0));
        chk_reset_outputs();
        @(negedge pclk);
        #2 rst = 1'b0;
        repeat (3) @(negedge pclk);
        chk("eng_no_start", 64'(ld_busy), 64'(0));

        // reset during DRAW of segment 2 of 3
        mem[AW'(BASE + 1)] = {8'd20, 8'd20, 8'd30, 8'd20};
        clear_obs();
        @(negedge pclk);
        start = 1'b1; num_segs = (AW+1)'(3);
        @(negedge pclk);
        start = 1'b0;
        k = 0;
        while (obs_ep.size() < 2 && k < BUDGET) begin @(negedge pclk); k++; end
        repeat (3) @(negedge pclk);
        chk("draw_busy", 64'(ld_busy), 64'(1));
        @(posedge pclk);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs();
        @(negedge pclk);
        #2 rst = 1'b0;
        k = 0;
        while (ld_busy && k < 100) begin @(negedge pclk); k++; end
        chk("eng_finish", 64'(ld_busy), 64'(0));
        run_frame(3, 1'b0);

`ifdef VSEQ_REPEAT_EN
        clear_obs();
        eng_deaf = 1'b0;
        repeat_i = 1'b1;
        @(negedge pclk);
        start = 1'b1; num_segs = (AW+1)'(2);
        @(negedge pclk);
        start = 1'b0;
        k = 0; lfd = 0; lows = 0;
        while (k < BUDGET && !(lfd == 2 && !busy)) begin
            if (frame_done) lfd++;
            else if (!busy) lows++;
            if (obs_ep.size() >= 3) repeat_i = 1'b0;
            @(negedge pclk);
            k++;
        end
        repeat_i = 1'b0;
        chk("rpt_passes", 64'(lfd), 64'(2));
        chk("rpt_busy_gap", 64'(lows), 64'(0));
        chk("rpt_end", 64'(busy), 64'(0));
        chk("rpt_rd_cnt", 64'(obs_addr.size()), 64'(4));
        for (int i = 0; i < 4 && i < obs_addr.size(); i++)
            chk("rpt_addr", 64'(obs_addr[i]), 64'(BASE + (i % 2)));
        chk("rpt_stable", 64'(stab_err), 64'(0));
`else
        lfd  = 0;
        lows = 0;
`endif

        repeat (2) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
